// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline definitions: Tuse/Tnew encodings and MDU latency defaults.
// Also included by the decoder so both sides agree on the encodings.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        TUSE_0    = 2'd0,
        TUSE_1    = 2'd1,
        TUSE_NONE = 2'd3
    } tuse_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t    REG_ZERO         = '0;
    localparam int unsigned DEF_MULT_CYCLES  = 5;
    localparam int unsigned DEF_DIV_CYCLES   = 10;
    localparam int unsigned DEF_CNT_W        = 4;

endpackage

// File: rtl/stall_ctrl_md_busy_counter.sv
// Multi-cycle multiply/divide sequencer: loads a latency on start when idle,
// counts down to zero, and ignores further starts until it is idle again.
module md_busy_counter
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end else if (start_i) begin
            count_d = is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign busy_o = (count_q != '0);
    assign done_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/stall_ctrl.sv
// D-stage hazard/stall controller: Tuse/Tnew RAW detection, MDU interlock,
// pipeline enable/flush generation and a saturating stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_start,
    input  logic        E_is_div,
    output logic        stall,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_en,
    output logic        DE_reset,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    logic        hazard_rs;
    logic        hazard_rt;
    logic        hazard_md;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // A source stalls only if a producer in E or M will not have its result
    // forwardable by the time the D instruction needs it.
    function automatic logic raw_hazard(
        input reg_idx_t   src,
        input logic [1:0] tuse,
        input reg_idx_t   e_a3,
        input logic [1:0] e_tnew,
        input reg_idx_t   m_a3,
        input logic [1:0] m_tnew
    );
        if (src == REG_ZERO || tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return ((e_a3 == src) && (tuse < e_tnew)) ||
               ((m_a3 == src) && (tuse < m_tnew));
    endfunction

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .start_i  (E_start),
        .is_div_i (E_is_div),
        .busy_o   (md_busy),
        .done_o   (md_done)
    );

    assign hazard_rs = raw_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
    assign hazard_rt = raw_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
    assign hazard_md = D_is_md && (md_busy || E_start);

    assign stall    = hazard_rs || hazard_rt || hazard_md;
    assign PC_en    = ~stall;
    assign FD_en    = ~stall;
    assign DE_en    = 1'b1;
    assign DE_reset = stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
